data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Memory-side responder for the data-memory interface driven by the load/store unit. It accepts one request at a time (read or write), holds it for a configurable access latency, then performs the access and pulses an acknowledge with the read data. It sits between the LSU's memory port and the data-memory array, and serves as both the synthesizable data memory and the bench memory model.

## Interface
- ADDR_WIDTH, 12, byte-address width of memory_req_address.
- DATA_WIDTH, 32, word width; equals the architectural register value width.
- DEPTH_WORDS, 1024, number of words in the array; must be a power of two and ≤ 2**(ADDR_WIDTH-2).
- LATENCY, 3, cycles from acceptance to ack; legal range 1..15.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high.
- memory_req_valid  in  1  request present.
- memory_req_op  in  memory_op_t  mem_read or mem_write; any other encoding is a no-op.
- memory_req_address  in  ADDR_WIDTH  byte address.
- memory_req_data  in  DATA_WIDTH  store data.
- memory_ready  out  1  responder can accept a request this cycle.
- memory_ack  out  1  one-cycle completion pulse.
- memory_data_return  out  DATA_WIDTH  load data; valid while memory_ack is high.

## Operation
- States: IDLE, WAIT, ACK. Reset state is IDLE.
- memory_ready = (state == IDLE). It is combinational from state only and never depends on memory_req_valid.
- Acceptance: memory_req_valid & memory_ready at a rising edge. That edge captures op, address and data, and loads the down-counter with LATENCY-1.
- IDLE -> ACK when the request is accepted and LATENCY == 1; otherwise IDLE -> WAIT.
- WAIT: the counter decrements each cycle. WAIT -> ACK on the edge where the counter reaches 0.
- ACK: memory_ack is high for exactly one cycle, then ACK -> IDLE unconditionally. The requester must not depend on the responder being ready during ACK.
- Word index = address[ADDR_WIDTH-1:2] modulo DEPTH_WORDS. address[1:0] is ignored, and higher index bits wrap.
- Read: memory_data_return is registered and loaded with mem[index] on the edge entering ACK.
- Write: mem[index] <= captured data on the edge entering ACK. memory_data_return is loaded with 0.
- No-op: no array access; memory_data_return is loaded with 0. The ack is still issued.
- Request inputs are ignored outside IDLE. Changes to the request inputs after acceptance have no effect.
- Array contents are not reset.

## Timing
- Reset values: memory_ready = 1, memory_ack = 0, memory_data_return = 0, counter = 0.
- Accept at edge E (cycle t): memory_ack is high during cycle t+LATENCY, and memory_ready is low for cycles t+1 .. t+LATENCY.
- Minimum request spacing is LATENCY+1 cycles; back-to-back throughput is one request per LATENCY+1 cycles.
- memory_data_return holds its value after ack until the next ACK entry.
- A write followed by a read of the same word: the read returns the new data. The write commits before ready returns.
- Reset asserted mid-request (WAIT or ACK): the request is abandoned, no write occurs, no ack is issued, and outputs return to their reset values immediately.

## Configuration
- DMEM_RANDOM_LATENCY_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4, reset value 8'hA5) advances once per accepted request.
  - The effective latency of each request is LATENCY + lfsr[1:0], i.e. LATENCY..LATENCY+3.
  - The extra cycles are sampled at acceptance.
- Not defined: latency is fixed at LATENCY, and the LFSR is absent.

## Test plan
- Reset check: hold reset for 3 cycles, then release. Outputs must be ready = 1, ack = 0, data_return = 0, with no ack for 10 idle cycles.
- Write then read, LATENCY = 3:
  - Write 32'hDEADBEEF to 12'h010, accepted at cycle t: ack at t+3 with data_return = 0.
  - Read 12'h010, accepted at t+4: ack at t+7 with data_return = 32'hDEADBEEF.
- Alignment and wrap, DEPTH_WORDS = 1024:
  - Writing 32'h1234_5678 to 12'h013 and reading 12'h010 returns 32'h1234_5678.
  - With ADDR_WIDTH = 13, address 13'h1010 aliases 13'h0010.
- Busy ignore: while in WAIT, change address and data and hold valid. The captured request completes unaltered, and the next acceptance occurs exactly one cycle after the ack.
- Mid-request reset: assert reset during WAIT of a write of 32'hAAAA_5555 to 12'h020. No ack is issued, and a subsequent read of 12'h020 returns the prior contents.
- With DMEM_RANDOM_LATENCY_EN defined, issue 50 requests:
  - Every ack latency must fall within LATENCY..LATENCY+3.
  - The latency sequence must match a reference LFSR seeded with 8'hA5.
  - Read data must stay correct throughout.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: LSU <-> data-memory request/ack bus and its op encoding
package data_memory_pkg;
   typedef enum logic [1:0] {
      mem_nop   = 2'd0,
      mem_read  = 2'd1,
      mem_write = 2'd2
   } memory_op_t;
endpackage

interface data_memory_responder_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   import data_memory_pkg::*;
   logic                  memory_req_valid;
   memory_op_t            memory_req_op;
   logic [ADDR_WIDTH-1:0] memory_req_address;
   logic [DATA_WIDTH-1:0] memory_req_data;
   logic                  memory_ready;
   logic                  memory_ack;
   logic [DATA_WIDTH-1:0] memory_data_return;
   modport master (
      output memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
      input  memory_ready, memory_ack, memory_data_return
   );
   modport slave (
      input  memory_req_valid, memory_req_op, memory_req_address, memory_req_data,
      output memory_ready, memory_ack, memory_data_return
   );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency word memory; DMEM_RANDOM_LATENCY_EN adds 0..3 LFSR-chosen extra cycles
module data_memory_responder
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 3
) (
   input logic clk,
   input logic reset,
   data_memory_responder_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
   state_t                state;
   logic [4:0]            cnt;
   logic [4:0]            lat_eff;
   memory_op_t            op_q;
   memory_op_t            sel_op;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      sel_idx;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic                  accept;
   logic                  enter_ack;

   assign bus.memory_ready = state == IDLE;
   assign accept = bus.memory_req_valid && state == IDLE;

`ifdef DMEM_RANDOM_LATENCY_EN
   logic [7:0] lfsr;
   // Fibonacci LFSR (taps 8,6,5,4) stepped once per accepted request
   always_ff @(posedge clk or posedge reset)
      if (reset) lfsr <= 8'hA5;
      else if (accept) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign lat_eff = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
   assign lat_eff = 5'(LATENCY);
`endif

   // Latency-1 requests complete straight from IDLE, so the access uses live inputs then
   always_comb begin
      sel_op   = accept ? bus.memory_req_op : op_q;
      sel_idx  = accept ? bus.memory_req_address[IDX_W+1:2] : idx_q;
      sel_data = accept ? bus.memory_req_data : data_q;
   end

   assign enter_ack = accept ? lat_eff == 5'd1 : (state == WAIT && cnt <= 5'd1);

   // Request FSM: capture on accept, count down in WAIT, one-cycle ACK with registered read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                  <= IDLE;
         cnt                    <= '0;
         op_q                   <= mem_nop;
         idx_q                  <= '0;
         data_q                 <= '0;
         bus.memory_ack         <= 1'b0;
         bus.memory_data_return <= '0;
      end else begin
         bus.memory_ack <= enter_ack;
         if (enter_ack) bus.memory_data_return <= sel_op == mem_read ? mem[sel_idx] : '0;
         if (accept) begin
            op_q   <= bus.memory_req_op;
            idx_q  <= bus.memory_req_address[IDX_W+1:2];
            data_q <= bus.memory_req_data;
         end
         case (state)
            IDLE: if (accept) begin
               cnt   <= lat_eff - 5'd1;
               state <= enter_ack ? ACK : WAIT;
            end
            WAIT: begin
               cnt   <= cnt - 5'd1;
               state <= enter_ack ? ACK : WAIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array write commits on ACK entry; contents are deliberately left unreset
   always_ff @(posedge clk)
      if (!reset && enter_ack && sel_op == mem_write) mem[sel_idx] <= sel_data;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed checks of latency, data, busy-ignore and reset abandonment
module tb_data_memory_responder;
   import data_memory_pkg::*;
   localparam int LAT = 3;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int n_err = 0;
   int n_chk = 0;
   logic [7:0] ref_lfsr = 8'hA5;
   logic [7:0] ref13 = 8'hA5;

   always #5 clk = ~clk;

   data_memory_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
   data_memory_responder_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) b13 ();

   data_memory_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   data_memory_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut13 (
      .clk(clk), .reset(reset), .bus(b13)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int next_lat(inout logic [7:0] r, input int base);
      int l = base;
`ifdef DMEM_RANDOM_LATENCY_EN
      l = base + int'(r[1:0]);
      r = {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
`endif
      return l;
   endfunction

   task automatic wait_ack(input string tag, input int exp_lat);
      int k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus.memory_ack) begin
            k = i;
            break;
         end
         chk({tag, "_ready_busy"}, 32'(bus.memory_ready), 32'd0);
      end
      chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic wait_ack13(input string tag, input int exp_lat);
      int k = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (b13.memory_ack) begin
            k = i;
            break;
         end
      end
      chk({tag, "_lat"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic req(input string tag, input memory_op_t op, input logic [11:0] a,
                      input logic [31:0] d, input logic [31:0] exp_dr);
      @(negedge clk);
      chk({tag, "_ready"}, 32'(bus.memory_ready), 32'd1);
      bus.memory_req_valid   = 1'b1;
      bus.memory_req_op      = op;
      bus.memory_req_address = a;
      bus.memory_req_data    = d;
      @(posedge clk);
      #1 bus.memory_req_valid = 1'b0;
      wait_ack(tag, next_lat(ref_lfsr, LAT));
      chk({tag, "_data"}, bus.memory_data_return, exp_dr);
   endtask

   task automatic req13(input string tag, input memory_op_t op, input logic [12:0] a,
                        input logic [31:0] d, input logic [31:0] exp_dr);
      @(negedge clk);
      b13.memory_req_valid   = 1'b1;
      b13.memory_req_op      = op;
      b13.memory_req_address = a;
      b13.memory_req_data    = d;
      @(posedge clk);
      #1 b13.memory_req_valid = 1'b0;
      wait_ack13(tag, next_lat(ref13, 1));
      chk({tag, "_data"}, b13.memory_data_return, exp_dr);
   endtask

   initial begin
      bus.memory_req_valid   = 1'b0;
      bus.memory_req_op      = mem_nop;
      bus.memory_req_address = '0;
      bus.memory_req_data    = '0;
      b13.memory_req_valid   = 1'b0;
      b13.memory_req_op      = mem_nop;
      b13.memory_req_address = '0;
      b13.memory_req_data    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.memory_ready), 32'd1);
      chk("rst_ack", 32'(bus.memory_ack), 32'd0);
      chk("rst_dr", bus.memory_data_return, 32'd0);
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         chk("idle_ack", 32'(bus.memory_ack), 32'd0);
      end
      chk("idle_ready", 32'(bus.memory_ready), 32'd1);
      chk("idle_dr", bus.memory_data_return, 32'd0);

      req("wr1", mem_write, 12'h010, 32'hDEADBEEF, 32'd0);
      req("rd1", mem_read, 12'h010, 32'd0, 32'hDEADBEEF);
      @(negedge clk);
      chk("hold_dr", bus.memory_data_return, 32'hDEADBEEF);

      req("wr_unal", mem_write, 12'h013, 32'h12345678, 32'd0);
      req("rd_al", mem_read, 12'h010, 32'd0, 32'h12345678);
      req("rd_al2", mem_read, 12'h012, 32'd0, 32'h12345678);
      req("wr_nb", mem_write, 12'h014, 32'hA1B2C3D4, 32'd0);
      req("rd_nb", mem_read, 12'h014, 32'd0, 32'hA1B2C3D4);
      req("rd_keep", mem_read, 12'h010, 32'd0, 32'h12345678);

      req("nop3", memory_op_t'(2'd3), 12'h010, 32'hFFFFFFFF, 32'd0);
      req("nop0", mem_nop, 12'h010, 32'hFFFFFFFF, 32'd0);
      req("rd_after_nop", mem_read, 12'h010, 32'd0, 32'h12345678);

      @(negedge clk);
      bus.memory_req_valid   = 1'b1;
      bus.memory_req_op      = mem_write;
      bus.memory_req_address = 12'h040;
      bus.memory_req_data    = 32'h11111111;
      @(posedge clk);
      #1;
      bus.memory_req_address = 12'h044;
      bus.memory_req_data    = 32'h22222222;
      wait_ack("busy1", next_lat(ref_lfsr, LAT));
      chk("busy1_data", bus.memory_data_return, 32'd0);
      @(negedge clk);
      chk("busy_next_ready", 32'(bus.memory_ready), 32'd1);
      @(posedge clk);
      #1 bus.memory_req_valid = 1'b0;
      wait_ack("busy2", next_lat(ref_lfsr, LAT));
      req("rd_busy1", mem_read, 12'h040, 32'd0, 32'h11111111);
      req("rd_busy2", mem_read, 12'h044, 32'd0, 32'h22222222);

      req("wr_prior", mem_write, 12'h020, 32'h5A5A0001, 32'd0);
      req("rd_set", mem_read, 12'h044, 32'd0, 32'h22222222);
      @(negedge clk);
      bus.memory_req_valid   = 1'b1;
      bus.memory_req_op      = mem_write;
      bus.memory_req_address = 12'h020;
      bus.memory_req_data    = 32'hAAAA5555;
      @(posedge clk);
      #1 bus.memory_req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mr_ready", 32'(bus.memory_ready), 32'd1);
      chk("mr_ack", 32'(bus.memory_ack), 32'd0);
      chk("mr_dr", bus.memory_data_return, 32'd0);
      ref_lfsr = 8'hA5;
      ref13 = 8'hA5;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("mr_no_ack", 32'(bus.memory_ack), 32'd0);
      end
      req("mr_rd", mem_read, 12'h020, 32'd0, 32'h5A5A0001);

      req13("w13", mem_write, 13'h1010, 32'hCAFEF00D, 32'd0);
      req13("r13_alias", mem_read, 13'h0010, 32'd0, 32'hCAFEF00D);
      req13("r13_same", mem_read, 13'h1012, 32'd0, 32'hCAFEF00D);

`ifdef DMEM_RANDOM_LATENCY_EN
      for (int i = 0; i < 50; i++) begin
         logic [11:0] a;
         a = 12'h100 + 12'(4 * ((i / 2) % 8));
         if (i % 2 == 0) req("rnd_wr", mem_write, a, 32'hC0DE0000 + 32'(i), 32'd0);
         else req("rnd_rd", mem_read, a, 32'd0, 32'hC0DE0000 + 32'(i - 1));
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
